cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Coprocessor-0 exception responder for the five-stage MIPS pipeline, sitting at the M stage. It consumes the exception information (`ExcCodeIn`, `BDIn`, PC) carried down the pipeline registers and samples the external hardware interrupts. It decides whether to take an exception or interrupt, and raises `Req`, which the pipeline registers use to flush and redirect fetch to the handler entry. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0`/`eret`.

## Interface
- `EXC_ENTRY`, 32'h0000_4180, handler entry address driven on `EntryPC` when `Req`=1
- `PRID_VALUE`, 32'h0000_2024, constant returned for PRId reads
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `en`  in  1  `mtc0` write enable from the M-stage instruction
- `addr`  in  5  CP0 register number for read/write (9, 12, 13, 14, 15 implemented)
- `wdata`  in  32  `mtc0` write data
- `rdata`  out  32  `mfc0` read data, combinational
- `PCIn`  in  32  PC of the M-stage instruction (0 for a bubble)
- `BDIn`  in  1  M-stage instruction sits in a branch delay slot
- `ExcCodeIn`  in  5  exception code of the M-stage instruction (0 = none)
- `HWInt`  in  6  level-sensitive hardware interrupt lines
- `eretIn`  in  1  M-stage instruction is `eret`
- `Req`  out  1  take exception/interrupt this cycle, combinational
- `EntryPC`  out  32  `EXC_ENTRY`
- `EPCOut`  out  32  return address for `eret`, with same-cycle `mtc0` EPC bypass

## Operation
- SR (12): IM = [15:10], EXL = [1], IE = [0]; other bits read 0, writes ignored.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; read-only to `mtc0`.
- EPC (14): `mtc0` writes [31:2]; [1:0] always 0.
- PRId (15) = `PRID_VALUE`. Unimplemented addresses read 0, writes ignored.
- IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- ExcReq = (ExcCodeIn != 0) & !SR.EXL.
- `Req` = (IntReq | ExcReq) & reset. An interrupt takes priority over a simultaneous exception.
- When `Req` is taken, on the next edge:
  - SR.EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? PCIn-4 : PCIn, with the low 2 bits cleared.
- `eretIn`=1 with `Req`=0: SR.EXL <= 0 on the next edge.
- Cause.IP <= HWInt on every edge, regardless of EXL.
- Simultaneous events:
  - `Req` blocks the `mtc0` write in the same cycle.
  - `Req` blocks `eret` in the same cycle.
  - `mtc0` to SR together with `eret`: the written value is applied, then EXL is cleared.
- `EPCOut` = (`en` & `addr`==14) ? {wdata[31:2],2'b00} : EPC. This covers `mtc0 EPC` immediately followed by `eret`.
- PC arithmetic is 32-bit wrap-around.

## Timing
- `Req`, `rdata`, `EPCOut` are combinational, with zero-cycle latency from inputs.
- Register writes land on the following rising edge. A same-cycle `mfc0` returns the old value, except via `EPCOut`.
- `reset`=0 asynchronously clears SR, Cause, EPC and Count (when compiled in) to 0 and forces `Req`=0. Release takes effect at the next edge.
- A reset mid-handler clears EXL, so interrupts stay masked until IE is set.
- Once EXL=1, neither exceptions nor interrupts re-raise `Req` until `eret`.

## Configuration
- `CP0_COUNT_EN` defined:
  - Count (9) is a 32-bit free-running counter, +1 every edge, wrapping at 2^32.
  - `mtc0` to Count loads `wdata`, and the increment resumes on the next edge.
  - Count reads the current value; reset value is 0.
- Undefined: no Count register; address 9 reads 0 and writes are ignored.

## Test plan
- Reset low mid-cycle with SR=32'h0000_FC03 -> SR, Cause, EPC read 0 immediately and `Req`=0.
- SR=32'h0000_0401, HWInt=6'b000001, PCIn=32'h3010, BDIn=0 -> `Req`=1 the same cycle; next edge EPC=32'h3010, Cause.ExcCode=0, SR.EXL=1.
- ExcCodeIn=5'd10, BDIn=1, PCIn=32'h3024 -> `Req`=1; EPC=32'h3020, Cause=32'h8000_0028.
- While EXL=1, ExcCodeIn=4 -> `Req`=0; then `eretIn`=1 -> EXL=0 next edge, and `EPCOut` equals EPC.
- `en`=1, `addr`=14, `wdata`=32'h3047 together with `eretIn`=1 -> `EPCOut`=32'h3044 that cycle; same cycle `Req`=1 with `en` to SR -> SR write dropped.
- With `CP0_COUNT_EN`: write Count=32'hFFFF_FFFE -> reads 32'hFFFF_FFFF, then 0 on successive cycles.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
// Coprocessor-0 exception responder for a five-stage MIPS pipeline (M stage).
// It decides whether the M-stage instruction traps or an external interrupt
// is taken. It raises Req so the pipeline flushes and fetch jumps to EntryPC.
// It also holds SR, Cause, EPC and PRId for mfc0 / mtc0 / eret.
//
// Optional feature: define CP0_COUNT_EN to build the free-running Count
// register (CP0 register 9). When it is undefined, address 9 reads 0 and
// writes to it are ignored.
//
// Ports
//   clk        in   1   system clock, rising-edge state updates
//   reset      in   1   asynchronous, active-low reset
//   en         in   1   mtc0 write enable
//   addr       in   5   CP0 register number (9, 12, 13, 14, 15 implemented)
//   wdata      in  32   mtc0 write data
//   rdata      out 32   mfc0 read data (combinational)
//   PCIn       in  32   PC of the M-stage instruction
//   BDIn       in   1   M-stage instruction is in a branch delay slot
//   ExcCodeIn  in   5   exception code of the M-stage instruction (0 = none)
//   HWInt      in   6   level-sensitive hardware interrupt lines
//   eretIn     in   1   M-stage instruction is eret
//   Req        out  1   take exception / interrupt this cycle (combinational)
//   EntryPC    out 32   handler entry address
//   EPCOut     out 32   eret return address, bypassing a same-cycle mtc0 EPC
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE = 32'h0000_2024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] PCIn,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        eretIn,
  output logic        Req,
  output logic [31:0] EntryPC,
  output logic [31:0] EPCOut
);

  localparam logic [4:0] ADDR_COUNT = 5'd9;
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Return address word (PC[31:2]); a delay-slot instruction resumes at its branch.
  function automatic logic [29:0] f_epc_word(input logic [31:0] pc, input logic bd);
    logic [31:0] ret_pc;
    ret_pc = bd ? (pc - 32'd4) : pc;
    return ret_pc[31:2];
  endfunction

  // SR fields
  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  // Cause fields
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  // EPC word address (low two bits are always 0)
  logic [29:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc;

  // Request decode: an exception level already in progress masks everything.
  always_comb begin
    w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    w_exc_req = (ExcCodeIn != 5'd0) & ~r_sr_exl;
    // reset gates Req so a held-in-reset pipeline never redirects
    w_req     = (w_int_req | w_exc_req) & reset;
    // a taken request squashes the M-stage mtc0
    w_wr_sr   = en & (addr == ADDR_SR) & ~w_req;
    w_wr_epc  = en & (addr == ADDR_EPC) & ~w_req;
  end

  // Architectural views of the packed registers.
  always_comb begin
    w_sr    = {16'h0000, r_sr_im, 8'h00, r_sr_exl, r_sr_ie};
    w_cause = {r_cause_bd, 15'h0000, r_cause_ip, 3'b000, r_cause_exc, 2'b00};
    w_epc   = {r_epc, 2'b00};
  end

  // SR: exception entry sets EXL; otherwise mtc0 applies first and eret clears EXL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr_im  <= 6'd0;
      r_sr_exl <= 1'b0;
      r_sr_ie  <= 1'b0;
    end else if (w_req) begin
      r_sr_exl <= 1'b1;
    end else begin
      if (w_wr_sr) begin
        r_sr_im <= wdata[15:10];
        r_sr_ie <= wdata[0];
      end else begin
        r_sr_im <= r_sr_im;
        r_sr_ie <= r_sr_ie;
      end
      if (eretIn) begin
        r_sr_exl <= 1'b0;
      end else if (w_wr_sr) begin
        r_sr_exl <= wdata[1];
      end else begin
        r_sr_exl <= r_sr_exl;
      end
    end
  end

  // Cause: IP tracks the interrupt lines every edge; BD/ExcCode latch on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
    end else begin
      r_cause_ip <= HWInt;
      if (w_req) begin
        r_cause_bd  <= BDIn;
        // an interrupt wins over a simultaneous exception and reports code 0
        r_cause_exc <= w_int_req ? 5'd0 : ExcCodeIn;
      end else begin
        r_cause_bd  <= r_cause_bd;
        r_cause_exc <= r_cause_exc;
      end
    end
  end

  // EPC: captured on entry, otherwise writable by mtc0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc <= 30'd0;
    end else if (w_req) begin
      r_epc <= f_epc_word(PCIn, BDIn);
    end else if (w_wr_epc) begin
      r_epc <= wdata[31:2];
    end else begin
      r_epc <= r_epc;
    end
  end

`ifdef CP0_COUNT_EN
  logic [31:0] r_count;
  logic        w_wr_count;

  // Count load strobe; a taken request squashes it like any other mtc0.
  always_comb begin
    w_wr_count = en & (addr == ADDR_COUNT) & ~w_req;
  end

  // Count: free-running wrap-around counter; a load replaces this edge's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= wdata;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end
`endif

  // mfc0 read mux: returns the pre-edge value of the addressed register.
  always_comb begin
    rdata = 32'd0;
    case (addr)
`ifdef CP0_COUNT_EN
      ADDR_COUNT: rdata = r_count;
`endif
      ADDR_SR:    rdata = w_sr;
      ADDR_CAUSE: rdata = w_cause;
      ADDR_EPC:   rdata = w_epc;
      ADDR_PRID:  rdata = PRID_VALUE;
      default:    rdata = 32'd0;
    endcase
  end

  // Pipeline-facing outputs; EPCOut forwards an in-flight mtc0 EPC so a
  // directly following eret sees the new return address.
  always_comb begin
    Req     = w_req;
    EntryPC = EXC_ENTRY;
    if (en && (addr == ADDR_EPC)) begin
      EPCOut = {wdata[31:2], 2'b00};
    end else begin
      EPCOut = w_epc;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_unit
// Self-checking bench for cp0_exc_unit: directed scenarios followed by
// randomized traffic, compared against a register-level behavioural model.
// Define CP0_COUNT_EN for both files to exercise the Count register.
// -----------------------------------------------------------------------------
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] PCIn;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        eretIn;
  logic        Req;
  logic [31:0] EntryPC;
  logic [31:0] EPCOut;

  int n_checks;
  int n_errors;

  // reference model state, kept as full 32-bit architectural values
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;
  logic [31:0] m_count;

  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  cp0_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .PCIn      (PCIn),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .eretIn    (eretIn),
    .Req       (Req),
    .EntryPC   (EntryPC),
    .EPCOut    (EPCOut)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic m_int_req();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    if (!reset) return 1'b0;
    return m_int_req() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rdata();
    case (addr)
`ifdef CP0_COUNT_EN
      5'd9:  return m_count;
`endif
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_2024;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epcout();
    if (en && addr == 5'd14) return wdata & 32'hFFFF_FFFC;
    return m_epc;
  endfunction

  task automatic model_clear();
    m_sr = 32'd0;
    m_cause = 32'd0;
    m_epc = 32'd0;
    m_count = 32'd0;
  endtask

  // One clock: check combinational outputs, then advance the model over the edge.
  task automatic tick(input string tag);
    logic        req;
    logic        wr;
    logic [31:0] n_sr, n_cause, n_epc, n_count;
    if (!reset) model_clear();
    #2;
    req = m_req();
    check({tag, ".Req"}, {31'd0, Req}, {31'd0, req});
    check({tag, ".rdata"}, rdata, m_rdata());
    check({tag, ".EPCOut"}, EPCOut, m_epcout());
    if (req) check({tag, ".EntryPC"}, EntryPC, 32'h0000_4180);
    wr = en && !req;
    n_sr = m_sr;
    n_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
    n_epc = m_epc;
    n_count = m_count + 32'd1;
    if (req) begin
      n_sr = m_sr | 32'h2;
      n_cause = ({31'd0, BDIn} << 31) | ({26'd0, HWInt} << 10)
              | (m_int_req() ? 32'd0 : ({27'd0, ExcCodeIn} << 2));
      n_epc = (BDIn ? PCIn - 32'd4 : PCIn) & 32'hFFFF_FFFC;
    end else begin
      if (wr && addr == 5'd12) n_sr = wdata & SR_MASK;
      if (eretIn) n_sr = n_sr & ~32'h2;
      if (wr && addr == 5'd14) n_epc = wdata & 32'hFFFF_FFFC;
      if (wr && addr == 5'd9) n_count = wdata;
    end
    @(posedge clk);
    if (reset) begin
      m_sr = n_sr;
      m_cause = n_cause;
      m_epc = n_epc;
      m_count = n_count;
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic idle();
    en = 1'b0; addr = 5'd0; wdata = 32'd0; PCIn = 32'd0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; HWInt = 6'd0; eretIn = 1'b0;
  endtask

  // Mid-cycle read without advancing the clock.
  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    en = 1'b0;
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    idle();
    reset = 1'b0;
    #1;
    tick("rst0");
    reset = 1'b1;
    tick("rel");

    // reset asserted mid-cycle with SR fully enabled
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03;
    tick("wr_sr");
    idle();
    HWInt = 6'h3F; ExcCodeIn = 5'd4;
    reset = 1'b0;
    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    check("rst_req", {31'd0, Req}, 32'd0);
    tick("rst_hold");
    idle();
    reset = 1'b1;
    tick("rst_rel");

    // interrupt entry
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    tick("sr401");
    idle();
    HWInt = 6'b000001; PCIn = 32'h0000_3010;
    #1 check("int_req", {31'd0, Req}, 32'd1);
    tick("int");
    idle();
    peek("int_epc", 5'd14, 32'h0000_3010);
    peek("int_code", 5'd13, 32'h0000_0400);
    peek("int_sr", 5'd12, 32'h0000_0403);
    tick("int_idle");

    // leave the handler, then a delay-slot exception
    idle(); eretIn = 1'b1;
    tick("eret1");
    idle(); ExcCodeIn = 5'd10; BDIn = 1'b1; PCIn = 32'h0000_3024;
    #1 check("exc_req", {31'd0, Req}, 32'd1);
    tick("exc");
    idle();
    peek("exc_epc", 5'd14, 32'h0000_3020);
    peek("exc_cause", 5'd13, 32'h8000_0028);

    // EXL masks further exceptions; eret exposes EPC
    idle(); ExcCodeIn = 5'd4;
    #1 check("exl_mask", {31'd0, Req}, 32'd0);
    tick("exl");
    idle(); eretIn = 1'b1; addr = 5'd12;
    #1 check("eret_epc", EPCOut, 32'h0000_3020);
    tick("eret2");
    idle();
    peek("eret_sr", 5'd12, 32'h0000_0401);

    // mtc0 EPC bypass alongside eret
    idle(); en = 1'b1; addr = 5'd14; wdata = 32'h0000_3047; eretIn = 1'b1;
    #1 check("epc_byp", EPCOut, 32'h0000_3044);
    tick("byp");
    // Req drops a same-cycle SR write
    idle(); en = 1'b1; addr = 5'd12; wdata = 32'd0; ExcCodeIn = 5'd5; PCIn = 32'h0000_3100;
    tick("req_blk");
    idle();
    peek("blk_sr", 5'd12, 32'h0000_0403);
    idle(); eretIn = 1'b1;
    tick("eret3");

`ifdef CP0_COUNT_EN
    idle(); en = 1'b1; addr = 5'd9; wdata = 32'hFFFF_FFFE;
    tick("cnt_ld");
    idle();
    peek("cnt0", 5'd9, 32'hFFFF_FFFE);
    tick("cnt_a");
    idle();
    peek("cnt1", 5'd9, 32'hFFFF_FFFF);
    tick("cnt_b");
    idle();
    peek("cnt2", 5'd9, 32'h0000_0000);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] addrs [6];
      addrs = '{5'd9, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
      idle();
      reset     = ($urandom_range(0, 49) != 0);
      en        = ($urandom_range(0, 9) < 4);
      addr      = addrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) addr = 5'($urandom_range(0, 31));
      wdata     = $urandom;
      PCIn      = $urandom;
      BDIn      = 1'($urandom_range(0, 1));
      ExcCodeIn = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      eretIn    = ($urandom_range(0, 5) == 0);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
